// File: rtl/rv32i_types_pkg.sv
// Shared RV32I datapath types: functional-unit writeback bus and completion-buffer slot layout.
package rv32i_types_pkg;

  localparam int NUM_CB_ENTRY = 16;

  typedef logic [31:0] word_t;
  typedef logic [$clog2(NUM_CB_ENTRY)-1:0] cb_idx_t;

  typedef struct packed {
    word_t      w_data;
    logic [4:0] reg_rd;
    logic       wen;
  } fu_out_t;

  typedef struct packed {
    logic       alloc;
    logic       done;
    logic       exc;
    logic       wen;
    logic [4:0] rd;
    word_t      wdata;
  } cb_entry_t;

endpackage

// File: rtl/cb_ptr_ctrl.sv
// Head/tail pointers with wrap bit for the completion buffer; derives full/empty and the allocate grant.
module cb_ptr_ctrl #(
  parameter int NUM_CB_ENTRY = 16,
  parameter int IDX_W        = $clog2(NUM_CB_ENTRY)
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             alloc_req,
  input  logic             commit,
  input  logic             flush,
  output logic [IDX_W-1:0] head_idx,
  output logic [IDX_W-1:0] tail_idx,
  output logic             push,
  output logic             full,
  output logic             empty
);

  localparam logic [IDX_W:0] PTR_ONE = 1;

  logic [IDX_W:0] head;
  logic [IDX_W:0] tail;
  logic [IDX_W:0] count;

  assign count    = tail - head;
  assign head_idx = head[IDX_W-1:0];
  assign tail_idx = tail[IDX_W-1:0];
  // Same slot index with opposite wrap bits means the tail has lapped the head.
  assign full     = (head[IDX_W] != tail[IDX_W]) && (head_idx == tail_idx);
  assign empty    = (count == '0);
  assign push     = alloc_req && !full;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      head <= '0;
      tail <= '0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (push)   tail <= tail + PTR_ONE;
      if (commit) head <= head + PTR_ONE;
    end
  end

endmodule

// File: rtl/completion_buffer.sv
// In-order retirement buffer: slots allocated at decode, filled out of order by the FUs,
// retired to the register file one per cycle in allocation order.
module completion_buffer #(
  parameter int NUM_CB_ENTRY = rv32i_types_pkg::NUM_CB_ENTRY,
  parameter int IDX_W        = $clog2(NUM_CB_ENTRY)
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic                     alloc_req,
  output logic [IDX_W-1:0]         alloc_idx,
  output logic                     full,
  output logic                     empty,
  input  logic                     ready_a,
  input  logic                     ready_mu,
  input  logic                     ready_du,
  input  logic                     ready_ls,
  input  logic [IDX_W-1:0]         index_a,
  input  logic [IDX_W-1:0]         index_mu,
  input  logic [IDX_W-1:0]         index_du,
  input  logic [IDX_W-1:0]         index_ls,
  input  rv32i_types_pkg::fu_out_t wb_a,
  input  rv32i_types_pkg::fu_out_t wb_mu,
  input  rv32i_types_pkg::fu_out_t wb_du,
  input  rv32i_types_pkg::fu_out_t wb_ls,
  input  logic                     exc_ls,
  input  logic                     stall_commit,
  input  logic                     flush,
  output logic                     commit_valid,
  output logic [IDX_W-1:0]         commit_idx,
  output logic [4:0]               commit_rd,
  output logic [31:0]              commit_wdata,
  output logic                     commit_wen,
  output logic                     commit_exc
);

  import rv32i_types_pkg::*;

  cb_entry_t        slots [NUM_CB_ENTRY];
  cb_entry_t        head_e;
  logic [IDX_W-1:0] head_idx;
  logic [IDX_W-1:0] tail_idx;
  logic             push;

  fu_out_t          wr_bus [NUM_CB_ENTRY];
  logic             wr_hit [NUM_CB_ENTRY];
  logic             wr_exc [NUM_CB_ENTRY];

  cb_ptr_ctrl #(
    .NUM_CB_ENTRY(NUM_CB_ENTRY),
    .IDX_W       (IDX_W)
  ) u_ptr (
    .CLK      (CLK),
    .nRST     (nRST),
    .alloc_req(alloc_req),
    .commit   (commit_valid),
    .flush    (flush),
    .head_idx (head_idx),
    .tail_idx (tail_idx),
    .push     (push),
    .full     (full),
    .empty    (empty)
  );

  assign alloc_idx = tail_idx;

  // Per-slot writeback select; colliding ports resolve a > mu > du > ls.
  always_comb begin
    for (int i = 0; i < NUM_CB_ENTRY; i++) begin
      wr_bus[i] = '0;
      wr_hit[i] = 1'b0;
      wr_exc[i] = 1'b0;
      if (ready_a && index_a == IDX_W'(i)) begin
        wr_bus[i] = wb_a;
        wr_hit[i] = 1'b1;
      end else if (ready_mu && index_mu == IDX_W'(i)) begin
        wr_bus[i] = wb_mu;
        wr_hit[i] = 1'b1;
      end else if (ready_du && index_du == IDX_W'(i)) begin
        wr_bus[i] = wb_du;
        wr_hit[i] = 1'b1;
      end else if (ready_ls && index_ls == IDX_W'(i)) begin
        wr_bus[i] = wb_ls;
        wr_hit[i] = 1'b1;
        wr_exc[i] = exc_ls;
      end
      wr_hit[i] = wr_hit[i] && slots[i].alloc;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < NUM_CB_ENTRY; i++) slots[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < NUM_CB_ENTRY; i++) begin
        slots[i].alloc <= 1'b0;
        slots[i].done  <= 1'b0;
        slots[i].exc   <= 1'b0;
      end
    end else begin
      for (int i = 0; i < NUM_CB_ENTRY; i++) begin
        if (wr_hit[i]) begin
          slots[i].done  <= 1'b1;
          slots[i].wdata <= wr_bus[i].w_data;
          slots[i].rd    <= wr_bus[i].reg_rd;
          slots[i].wen   <= wr_bus[i].wen;
          slots[i].exc   <= wr_exc[i];
        end
        if (commit_valid && head_idx == IDX_W'(i)) begin
          slots[i].alloc <= 1'b0;
          slots[i].done  <= 1'b0;
        end
        // Tail never equals a committing head here: push needs !full and commit needs !empty.
        if (push && tail_idx == IDX_W'(i)) begin
          slots[i].alloc <= 1'b1;
          slots[i].done  <= 1'b0;
          slots[i].exc   <= 1'b0;
        end
      end
    end
  end

  assign head_e       = slots[head_idx];
  assign commit_valid = !empty && head_e.done && !stall_commit && !flush;
  assign commit_idx   = empty ? '0 : head_idx;
  assign commit_rd    = empty ? '0 : head_e.rd;
  assign commit_wdata = empty ? '0 : head_e.wdata;
  assign commit_exc   = !empty && head_e.exc;
  assign commit_wen   = commit_valid && head_e.wen && (head_e.rd != 5'd0);

endmodule

// File: doc/completion_buffer.md
Name: completion_buffer

Overview:
- In-order retirement buffer sitting between the functional units (arith, mul, div, lsu) and the register file.
- Decode allocates one slot per issued instruction. The slot index travels with the FU control signals (index_a/index_mu/index_du/index_ls).
- FUs write back out of order by index. The buffer commits results to the register file strictly in allocation order, one per cycle.
- This block is the receiving end of the FU index/ready interface carried in the shared control-signal structs.

Parameters:
- NUM_CB_ENTRY, 16, number of slots; must be a power of two, ≥2.
- IDX_W, $clog2(NUM_CB_ENTRY), slot index width.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- alloc_req  in  1  decode requests a slot this cycle.
- alloc_idx  out  IDX_W  index granted; equals the current tail.
- full  out  1  count == NUM_CB_ENTRY.
- empty  out  1  count == 0.
- ready_a / ready_mu / ready_du / ready_ls  in  1 each  writeback strobe per FU.
- index_a / index_mu / index_du / index_ls  in  IDX_W each  slot being written.
- wb_a / wb_mu / wb_du / wb_ls  in  fu_out_t each  {w_data, reg_rd, wen}.
- exc_ls  in  1  lsu result carries a fault.
- stall_commit  in  1  hold retirement.
- flush  in  1  discard all slots.
- commit_valid  out  1  head slot retires this cycle.
- commit_idx  out  IDX_W  head index.
- commit_rd  out  5  destination register.
- commit_wdata  out  32  result data.
- commit_wen  out  1  register file write enable.
- commit_exc  out  1  head slot faulted.

Behaviour:
- State:
  - head and tail pointers, each IDX_W+1 bits including a wrap bit.
  - Per slot: alloc, done, wdata, rd, wen, exc.
  - count = tail − head (IDX_W+1 bits).
- Reset (nRST low, async): head = tail = 0; all alloc/done/exc = 0.
  - Consequently full = 0, empty = 1, commit_valid = 0, and all commit_* outputs = 0.
- Allocate:
  - alloc_idx = tail[IDX_W-1:0], combinational.
  - When alloc_req && !full: slot[tail].alloc = 1, done = 0, exc = 0; tail increments on the edge.
  - alloc_req while full: ignored, no state change. Decode must stall on full.
  - full is computed from the registered count, so a commit in the same cycle does not admit an allocation.
- Writeback: for each port with ready_x high and slot[index_x].alloc = 1:
  - Next edge: done = 1; wdata/rd/wen taken from wb_x; exc = exc_ls (ls port only, 0 otherwise).
  - Writes to an unallocated slot are ignored and flagged by a bench assertion.
  - Two ports targeting the same index in one cycle is illegal. If it happens, priority is a > mu > du > ls.
  - A write to an already-done slot overwrites it (legal only for the same FU). The bench flags it.
- Commit:
  - commit_valid = !empty && slot[head].done && !stall_commit, combinational from registered state.
  - commit_idx/rd/wdata/exc reflect the head slot whenever !empty; all zeros when empty.
  - commit_wen = commit_valid && slot.wen && (rd != 0).
  - On commit_valid: head increments; slot alloc/done cleared.
  - Minimum writeback-to-commit latency is 1 cycle. There is no same-cycle bypass.
- Simultaneous events:
  - Alloc, up to 4 writebacks, and commit may all occur in one cycle.
  - A writeback to the head slot in the cycle it would commit is not seen until the next cycle.
- Wrap-around: pointers wrap modulo 2·NUM_CB_ENTRY. full ⇔ index bits equal and wrap bits differ.
- commit_exc: informational only. The buffer does not self-flush. The exception unit asserts flush.
- flush (synchronous) has priority over alloc, writeback and commit in the same cycle.
  - Next cycle: head = tail = 0; all alloc/done/exc = 0.
  - commit_valid is forced 0 in the flush cycle.
- Reset mid-operation: immediately returns to reset state; in-flight writebacks are lost.

Decomposition:
- Into rv32i_types_pkg:
  - NUM_CB_ENTRY (already present).
  - cb_entry_t struct {alloc, done, exc, wen, rd[4:0], wdata word_t}.
  - cb_idx_t = logic [$clog2(NUM_CB_ENTRY)-1:0].
- fu_out_t is reused for the writeback buses.
- One sub-module: cb_ptr_ctrl (head/tail pointers, count, full/empty). The slot array and writeback muxing stay in completion_buffer.

Test Plan:
- Reset, then 3 allocs → alloc_idx 0,1,2; full = 0, empty = 0. wb_ls to idx 1 (rd = 5, 0xAA) → commit_valid stays 0. wb_a to idx 0 (rd = 3, 0x11) → next cycle commits rd 3 = 0x11, then rd 5 = 0xAA; idx 2 holds.
- 16 allocs → full = 1; 17th alloc ignored, tail unchanged. Complete and commit idx 0 → full = 0 next cycle; alloc returns idx 0 (wrap).
- Same-cycle writebacks on all four ports to idx 0–3 in reverse order → commits idx 0,1,2,3 on 4 consecutive cycles with matching data.
- wb_a with reg_rd = 0, wen = 1 → commit_valid = 1, commit_wen = 0.
- exc_ls = 1 on head slot → commit_exc = 1. flush asserted with alloc_req → next cycle empty = 1, alloc_idx = 0, no commit.
- stall_commit high for 5 cycles with done head → commit_valid = 0 throughout; releases with the same head data. nRST pulsed mid-stream → all outputs zero immediately.
